// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared types and constants for the Viterbi frame sequencer
package viterbi_pkg;

  localparam int K                 = 3;
  localparam int NUM_STATES        = 2 ** K;
  localparam int DEFAULT_BLOCK_LEN = 64;
  localparam int PM_W              = 8;

  // ACS starts from state 0 as the only plausible origin
  localparam logic [PM_W-1:0] PM_INIT_ZERO = '0;
  localparam logic [PM_W-1:0] PM_INIT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    FWD,
    DRAIN,
    TB,
    TB_TAIL,
    OUT
  } vit_state_t;

  function automatic logic [PM_W-1:0] init_metric(input logic [$clog2(NUM_STATES)-1:0] st);
    return (st == '0) ? PM_INIT_ZERO : PM_INIT_MAX;
  endfunction

endpackage

// File: rtl/viterbi_ctrl_if.sv
// rtl/viterbi_ctrl_if.sv - channel, datapath and sink signals of the Viterbi sequencer
interface viterbi_ctrl_if
  import viterbi_pkg::*;
#(
  parameter int AW = $clog2(DEFAULT_BLOCK_LEN)
);

  logic          rx_valid;
  logic [1:0]    rx_pair;
  logic          rx_ready;
  logic [1:0]    bmc_pair;
  logic          acs_en;
  logic          acs_init;
  logic          sm_we;
  logic          sm_rd_en;
  logic [AW-1:0] sm_addr;
  logic          tb_start;
  logic          tb_bit;
  logic          out_valid;
  logic          out_bit;
  logic          out_ready;
  logic          frame_done;

  modport master (
    input  rx_valid, rx_pair, tb_bit, out_ready,
    output rx_ready, bmc_pair, acs_en, acs_init, sm_we, sm_rd_en, sm_addr,
           tb_start, out_valid, out_bit, frame_done
  );

  modport slave (
    output rx_valid, rx_pair, tb_bit, out_ready,
    input  rx_ready, bmc_pair, acs_en, acs_init, sm_we, sm_rd_en, sm_addr,
           tb_start, out_valid, out_bit, frame_done
  );

endinterface

// File: rtl/vit_out_buf.sv
// rtl/vit_out_buf.sv - decoded-bit buffer, written in traceback order, read in transmit order
module vit_out_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  logic [DEPTH-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/viterbi_ctrl.sv
// rtl/viterbi_ctrl.sv - frame sequencer: symbol intake, ACS/survivor writes, traceback, ordered output
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int BLOCK_LEN = DEFAULT_BLOCK_LEN,
  parameter int AW        = $clog2(BLOCK_LEN)
) (
  input  logic           clk,
  input  logic           rst,
  viterbi_ctrl_if.master bus
);

  localparam logic [AW-1:0] LAST = AW'(BLOCK_LEN - 1);

  vit_state_t    state;
  logic [AW-1:0] sym_cnt;
  logic [AW-1:0] tb_cnt;
  logic [AW-1:0] out_cnt;
  logic [AW-1:0] cap_addr;
  logic          cap_en;
  logic          rd_bit;
  logic          accept;

  logic          rx_ready_q;
  logic [1:0]    bmc_pair_q;
  logic          acs_en_q;
  logic          acs_init_q;
  logic          sm_we_q;
  logic          sm_rd_en_q;
  logic [AW-1:0] sm_addr_q;
  logic          tb_start_q;
  logic          out_valid_q;
  logic          frame_done_q;

  assign accept = bus.rx_valid & rx_ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sym_cnt      <= '0;
      tb_cnt       <= '0;
      out_cnt      <= '0;
      cap_addr     <= '0;
      cap_en       <= 1'b0;
      rx_ready_q   <= 1'b1;
      bmc_pair_q   <= '0;
      acs_en_q     <= 1'b0;
      acs_init_q   <= 1'b0;
      sm_we_q      <= 1'b0;
      sm_rd_en_q   <= 1'b0;
      sm_addr_q    <= '0;
      tb_start_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      acs_en_q     <= 1'b0;
      acs_init_q   <= 1'b0;
      sm_we_q      <= 1'b0;
      sm_rd_en_q   <= 1'b0;
      tb_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      // tb_bit answers the read issued one cycle earlier
      cap_en       <= sm_rd_en_q;
      cap_addr     <= sm_addr_q;

      case (state)
        IDLE: begin
          if (accept) begin
            bmc_pair_q <= bus.rx_pair;
            acs_en_q   <= 1'b1;
            acs_init_q <= 1'b1;
            sm_we_q    <= 1'b1;
            sm_addr_q  <= '0;
            sym_cnt    <= AW'(1);
            state      <= FWD;
          end
        end
        FWD: begin
          if (accept) begin
            bmc_pair_q <= bus.rx_pair;
            acs_en_q   <= 1'b1;
            sm_we_q    <= 1'b1;
            sm_addr_q  <= sym_cnt;
            if (sym_cnt == LAST) begin
              sym_cnt    <= '0;
              rx_ready_q <= 1'b0;
              state      <= DRAIN;
            end else begin
              sym_cnt <= sym_cnt + AW'(1);
            end
          end
        end
        DRAIN: begin
          tb_cnt     <= LAST;
          sm_addr_q  <= LAST;
          sm_rd_en_q <= 1'b1;
          tb_start_q <= 1'b1;
          state      <= TB;
        end
        TB: begin
          if (tb_cnt == '0) begin
            state <= TB_TAIL;
          end else begin
            tb_cnt     <= tb_cnt - AW'(1);
            sm_addr_q  <= tb_cnt - AW'(1);
            sm_rd_en_q <= 1'b1;
          end
        end
        TB_TAIL: begin
          out_cnt     <= '0;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            if (out_cnt == LAST) begin
              out_cnt      <= '0;
              out_valid_q  <= 1'b0;
              frame_done_q <= 1'b1;
              rx_ready_q   <= 1'b1;
              state        <= IDLE;
            end else begin
              out_cnt <= out_cnt + AW'(1);
            end
          end
        end
        default: begin
          rx_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  vit_out_buf #(
    .DEPTH (BLOCK_LEN),
    .AW    (AW)
  ) u_out_buf (
    .clk   (clk),
    .rst_n (rst),
    .we    (cap_en),
    .waddr (cap_addr),
    .wdata (bus.tb_bit),
    .raddr (out_cnt),
    .rdata (rd_bit)
  );

  assign bus.rx_ready   = rx_ready_q;
  assign bus.bmc_pair   = bmc_pair_q;
  assign bus.acs_en     = acs_en_q;
  assign bus.acs_init   = acs_init_q;
  assign bus.sm_we      = sm_we_q;
  assign bus.sm_rd_en   = sm_rd_en_q;
  assign bus.sm_addr    = sm_addr_q;
  assign bus.tb_start   = tb_start_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_bit    = out_valid_q & rd_bit;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb/tb_viterbi_ctrl.sv - self-checking bench for viterbi_ctrl with BLOCK_LEN=8
module tb_viterbi_ctrl;
  import viterbi_pkg::*;

  localparam int BL = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  viterbi_ctrl_if #(.AW(AW)) bus ();

  viterbi_ctrl #(.BLOCK_LEN(BL), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // frame stimulus and the traceback unit's answer for each survivor address
  logic [1:0] pairs[BL];
  logic       bit_table[BL];

  int         cyc;
  int         first_ov;
  int         acc_cyc[$];
  int         wr_cyc[$];
  int         wr_addr[$];
  logic       wr_init[$];
  logic [1:0] wr_pair[$];
  int         rd_cyc[$];
  int         rd_addr[$];
  logic       rd_start[$];
  int         hs_cyc[$];
  logic       hs_bit[$];
  int         fd_cyc[$];
  logic [1:0] bmc_log[$];
  logic       rdy_log[$];

  logic prev_rd, prev_ov, prev_ordy, prev_bit;
  int   prev_addr;

  task automatic clear_logs();
    cyc = 0;
    first_ov = -1;
    acc_cyc.delete(); wr_cyc.delete(); wr_addr.delete(); wr_init.delete(); wr_pair.delete();
    rd_cyc.delete(); rd_addr.delete(); rd_start.delete(); hs_cyc.delete(); hs_bit.delete();
    fd_cyc.delete(); bmc_log.delete(); rdy_log.delete();
  endtask

  // log the current cycle, advance one clock, then play the traceback unit
  task automatic tick();
    if (bus.rx_valid && bus.rx_ready) acc_cyc.push_back(cyc);
    if (bus.sm_we) begin
      wr_cyc.push_back(cyc); wr_addr.push_back(int'(bus.sm_addr));
      wr_init.push_back(bus.acs_init); wr_pair.push_back(bus.bmc_pair);
    end
    if (bus.sm_rd_en) begin
      rd_cyc.push_back(cyc); rd_addr.push_back(int'(bus.sm_addr)); rd_start.push_back(bus.tb_start);
    end
    if (bus.out_valid && bus.out_ready) begin
      hs_cyc.push_back(cyc); hs_bit.push_back(bus.out_bit);
    end
    if (bus.out_valid && first_ov < 0) first_ov = cyc;
    bmc_log.push_back(bus.bmc_pair);
    rdy_log.push_back(bus.rx_ready);
    checks += 2;
    if (bus.acs_en !== bus.sm_we) begin
      failures++; $display("FAIL acs_en_eq_sm_we: acs_en=%b sm_we=%b", bus.acs_en, bus.sm_we);
    end
    if (bus.sm_we === 1'b1 && bus.sm_rd_en === 1'b1) begin
      failures++; $display("FAIL we_rd_exclusive: sm_we=1 sm_rd_en=1 required not both");
    end
    prev_rd = bus.sm_rd_en; prev_addr = int'(bus.sm_addr);
    prev_ov = bus.out_valid; prev_ordy = bus.out_ready; prev_bit = bus.out_bit;
    @(posedge clk); #1;
    cyc++;
    bus.tb_bit = prev_rd ? bit_table[prev_addr] : 1'($urandom);
    if (prev_ov && !prev_ordy && bus.out_valid) begin
      checks++;
      if (bus.out_bit !== prev_bit) begin
        failures++; $display("FAIL stall_hold: out_bit=%b required %b", bus.out_bit, prev_bit);
      end
    end
  endtask

  // gap_mode 0: continuous, 1: valid 1,0,0 pattern, 2: random
  // stall_at >= 0: hold out_ready low stall_len cycles after that many handshakes; -2: random ready
  task automatic run_frame(input int gap_mode, input int stall_at, input int stall_len,
                           input int abort_addr, output bit aborted);
    int idx = 0;
    int stalled = 0;
    int budget = 0;
    bit done = 0;
    bit acc;
    aborted = 0;
    clear_logs();
    while (!done && !aborted && budget < 400) begin
      if (idx < BL) begin
        case (gap_mode)
          0:       bus.rx_valid = 1'b1;
          1:       bus.rx_valid = (budget % 3 == 0);
          default: bus.rx_valid = 1'($urandom);
        endcase
        bus.rx_pair = bus.rx_valid ? pairs[idx] : 2'($urandom);
      end else begin
        bus.rx_valid = 1'b0;
        bus.rx_pair  = 2'($urandom);
      end
      if (stall_at == -2) begin
        bus.out_ready = 1'($urandom);
      end else if (hs_bit.size() == stall_at && stalled < stall_len && bus.out_valid) begin
        bus.out_ready = 1'b0;
        stalled++;
      end else begin
        bus.out_ready = 1'b1;
      end
      acc = bus.rx_valid && bus.rx_ready;
      tick();
      if (acc) idx++;
      if (abort_addr >= 0 && bus.sm_rd_en && int'(bus.sm_addr) == abort_addr) aborted = 1;
      if (bus.frame_done) begin
        fd_cyc.push_back(cyc);
        done = 1;
      end
      budget++;
    end
    bus.rx_valid = 1'b0;
    checks++;
    if (!done && !aborted) begin
      failures++; $display("FAIL frame_timeout: no frame_done within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < BL; i++) begin
      pairs[i] = 2'($urandom);
      bit_table[i] = 1'($urandom);
    end
  endtask

  task automatic check_out_bits(input string name);
    checks++;
    if (hs_bit.size() != BL) begin
      failures++; $display("FAIL %s_count: handshakes=%0d required %0d", name, hs_bit.size(), BL);
    end else begin
      for (int k = 0; k < BL; k++) begin
        checks++;
        if (hs_bit[k] !== bit_table[k]) begin
          failures++; $display("FAIL %s_bit%0d: out_bit=%b required %b", name, k, hs_bit[k], bit_table[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [14:0] rest;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.rx_valid = 1'($urandom); bus.rx_pair = 2'($urandom);
      bus.tb_bit = 1'($urandom); bus.out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    rest = {bus.bmc_pair, bus.acs_en, bus.acs_init, bus.sm_we, bus.sm_rd_en, bus.sm_addr,
            bus.tb_start, bus.out_valid, bus.out_bit, bus.frame_done, 2'b00};
    checks += 3;
    if (bus.rx_ready !== 1'b1) begin
      failures++; $display("FAIL reset_rx_ready: got %b required 1", bus.rx_ready);
    end
    if (rest !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h required 0", rest);
    end
    if (dut.state !== IDLE) begin
      failures++; $display("FAIL reset_state: got %0d required IDLE", dut.state);
    end
    rst = 1'b1;
    bus.rx_valid = 1'b1; bus.rx_pair = 2'b10; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    checks += 3;
    if ({bus.acs_init, bus.acs_en, bus.sm_we} !== 3'b111) begin
      failures++; $display("FAIL first_accept_strobes: got %b required 111", {bus.acs_init, bus.acs_en, bus.sm_we});
    end
    if (bus.sm_addr !== 3'd0) begin
      failures++; $display("FAIL first_accept_addr: got %0d required 0", bus.sm_addr);
    end
    if (bus.bmc_pair !== 2'b10) begin
      failures++; $display("FAIL first_accept_pair: got %b required 10", bus.bmc_pair);
    end
    do_reset();
  endtask

  task automatic test_streaming();
    bit ab;
    logic [1:0] fixed[BL] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b10};
    for (int i = 0; i < BL; i++) begin
      pairs[i] = fixed[i];
      bit_table[i] = 1'($urandom);
    end
    run_frame(0, -1, 0, -1, ab);
    checks++;
    if (wr_addr.size() != BL || acc_cyc.size() != BL || rd_addr.size() != BL) begin
      failures++;
      $display("FAIL stream_counts: writes=%0d accepts=%0d reads=%0d required %0d", wr_addr.size(), acc_cyc.size(), rd_addr.size(), BL);
    end else begin
      for (int k = 0; k < BL; k++) begin
        checks += 7;
        if (wr_addr[k] != k) begin failures++; $display("FAIL stream_waddr%0d: got %0d required %0d", k, wr_addr[k], k); end
        if (wr_cyc[k] != acc_cyc[k] + 1) begin failures++; $display("FAIL stream_wlat%0d: got %0d required %0d", k, wr_cyc[k], acc_cyc[k] + 1); end
        if (wr_cyc[k] != wr_cyc[0] + k) begin failures++; $display("FAIL stream_wcontig%0d: got %0d required %0d", k, wr_cyc[k], wr_cyc[0] + k); end
        if (wr_init[k] !== (k == 0)) begin failures++; $display("FAIL stream_init%0d: got %b required %b", k, wr_init[k], k == 0); end
        if (wr_pair[k] !== pairs[k]) begin failures++; $display("FAIL stream_pair%0d: got %b required %b", k, wr_pair[k], pairs[k]); end
        if (rd_addr[k] != BL - 1 - k || rd_cyc[k] != wr_cyc[BL-1] + 1 + k) begin
          failures++; $display("FAIL stream_raddr%0d: addr=%0d cyc=%0d required addr=%0d cyc=%0d", k, rd_addr[k], rd_cyc[k], BL - 1 - k, wr_cyc[BL-1] + 1 + k);
        end
        if (rd_start[k] !== (k == 0)) begin failures++; $display("FAIL stream_tbstart%0d: got %b required %b", k, rd_start[k], k == 0); end
      end
      checks += 2;
      if (rdy_log[acc_cyc[BL-1] + 1] !== 1'b0) begin
        failures++; $display("FAIL stream_rx_ready_drop: got %b required 0", rdy_log[acc_cyc[BL-1] + 1]);
      end
      if (first_ov != wr_cyc[BL-1] + 10) begin
        failures++; $display("FAIL stream_out_latency: got %0d required %0d", first_ov, wr_cyc[BL-1] + 10);
      end
    end
    check_out_bits("stream");
  endtask

  task automatic test_reverse_order();
    bit ab;
    randomize_frame();
    for (int a = 0; a < BL; a++) bit_table[a] = a[0];
    run_frame(0, -1, 0, -1, ab);
    checks++;
    if (hs_bit.size() != BL) begin
      failures++; $display("FAIL rev_count: got %0d required %0d", hs_bit.size(), BL);
    end else begin
      for (int k = 0; k < BL; k++) begin
        checks++;
        if (hs_bit[k] !== 1'(k % 2)) begin
          failures++; $display("FAIL rev_bit%0d: got %b required %0d", k, hs_bit[k], k % 2);
        end
      end
      checks++;
      if (fd_cyc.size() != 1 || fd_cyc[0] != hs_cyc[BL-1] + 1) begin
        failures++; $display("FAIL rev_fd_timing: fd_seen=%0d required one pulse after last handshake", fd_cyc.size());
      end
    end
    tick();
    checks++;
    if (bus.frame_done !== 1'b0) begin
      failures++; $display("FAIL rev_fd_width: frame_done=%b required 0 on second cycle", bus.frame_done);
    end
  endtask

  task automatic test_input_gaps();
    bit ab;
    int j;
    randomize_frame();
    run_frame(1, -1, 0, -1, ab);
    checks++;
    if (wr_addr.size() != BL || acc_cyc.size() != BL) begin
      failures++; $display("FAIL gap_counts: writes=%0d accepts=%0d required %0d", wr_addr.size(), acc_cyc.size(), BL);
    end else begin
      for (int k = 0; k < BL; k++) begin
        checks += 2;
        if (wr_addr[k] != k) begin failures++; $display("FAIL gap_waddr%0d: got %0d required %0d", k, wr_addr[k], k); end
        if (wr_cyc[k] != acc_cyc[k] + 1) begin failures++; $display("FAIL gap_wlat%0d: got %0d required %0d", k, wr_cyc[k], acc_cyc[k] + 1); end
      end
      for (int c = acc_cyc[0] + 1; c <= acc_cyc[BL-1] + 1; c++) begin
        j = 0;
        foreach (acc_cyc[i]) if (acc_cyc[i] < c) j++;
        checks++;
        if (bmc_log[c] !== pairs[j-1]) begin
          failures++; $display("FAIL gap_bmc_hold_c%0d: got %b required %b", c, bmc_log[c], pairs[j-1]);
        end
      end
    end
    check_out_bits("gap");
  endtask

  task automatic test_back_pressure();
    bit ab;
    logic [1:0] p;
    randomize_frame();
    run_frame(0, 3, 5, -1, ab);
    check_out_bits("bp");
    checks++;
    if (hs_cyc.size() != BL || fd_cyc.size() != 1) begin
      failures++; $display("FAIL bp_fd: handshakes=%0d fd=%0d required %0d and 1", hs_cyc.size(), fd_cyc.size(), BL);
    end else begin
      checks += 2;
      if (hs_cyc[3] != hs_cyc[2] + 6) begin
        failures++; $display("FAIL bp_stall_len: gap=%0d required 6", hs_cyc[3] - hs_cyc[2]);
      end
      if (fd_cyc[0] != hs_cyc[BL-1] + 1) begin
        failures++; $display("FAIL bp_fd_timing: got %0d required %0d", fd_cyc[0], hs_cyc[BL-1] + 1);
      end
    end
    p = 2'($urandom);
    bus.rx_valid = 1'b1; bus.rx_pair = p;
    checks++;
    if (bus.rx_ready !== 1'b1) begin
      failures++; $display("FAIL bp_ready_in_fd: rx_ready=%b required 1", bus.rx_ready);
    end
    tick();
    bus.rx_valid = 1'b0;
    checks++;
    if ({bus.sm_we, bus.acs_init, bus.sm_addr, bus.bmc_pair} !== {1'b1, 1'b1, 3'd0, p}) begin
      failures++; $display("FAIL bp_second_frame: we=%b init=%b addr=%0d pair=%b required 1 1 0 %b", bus.sm_we, bus.acs_init, bus.sm_addr, bus.bmc_pair, p);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    bit ab;
    randomize_frame();
    run_frame(0, -1, 0, 4, ab);
    checks++;
    if (!ab) begin
      failures++; $display("FAIL mid_reach_tb4: traceback addr 4 not seen");
    end
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    #1;
    checks += 2;
    if (dut.state !== IDLE) begin
      failures++; $display("FAIL mid_state: got %0d required IDLE", dut.state);
    end
    if ({bus.rx_ready, bus.out_valid, bus.sm_rd_en, bus.tb_start} !== 4'b1000) begin
      failures++; $display("FAIL mid_outputs: got %b required 1000", {bus.rx_ready, bus.out_valid, bus.sm_rd_en, bus.tb_start});
    end
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
        failures++; $display("FAIL mid_no_output%0d: out_valid=%b frame_done=%b required 0 0", i, bus.out_valid, bus.frame_done);
      end
    end
    randomize_frame();
    run_frame(0, -1, 0, -1, ab);
    checks++;
    if (wr_init.size() == 0 || wr_init[0] !== 1'b1 || wr_addr[0] != 0) begin
      failures++; $display("FAIL mid_restart_init: writes=%0d required first write init at addr 0", wr_init.size());
    end
    check_out_bits("mid");
  endtask

  task automatic test_random_frames();
    bit ab;
    for (int f = 0; f < 3; f++) begin
      randomize_frame();
      run_frame(2, -2, 0, -1, ab);
      checks++;
      if (wr_addr.size() != BL || rd_addr.size() != BL) begin
        failures++; $display("FAIL rnd%0d_counts: writes=%0d reads=%0d required %0d", f, wr_addr.size(), rd_addr.size(), BL);
      end else begin
        for (int k = 0; k < BL; k++) begin
          checks++;
          if (wr_addr[k] != k || rd_addr[k] != BL - 1 - k || wr_pair[k] !== pairs[k]) begin
            failures++; $display("FAIL rnd%0d_addr%0d: w=%0d r=%0d pair=%b required w=%0d r=%0d pair=%b", f, k, wr_addr[k], rd_addr[k], wr_pair[k], k, BL - 1 - k, pairs[k]);
          end
        end
      end
      check_out_bits("rnd");
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_pair = 2'b00;
    bus.tb_bit = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_streaming();
    test_reverse_order();
    test_input_gaps();
    test_back_pressure();
    test_reset_mid();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
